mac_vector_sequencer: RTL and testbench
=======================================

MAC_VECTOR_SEQUENCER -- requirements
Module: mac_vector_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, operand FIFO depth in pairs.
REQ-002 SHALL have parameter LAT, default 5, edges from final pair loaded on mac_a/mac_b to result capture.
REQ-003 SHALL have port clk  in  1  clock; reset rst, asynchronous, active-low.
REQ-004 SHALL have port rst  in  1  asynchronous active-low reset.
REQ-005 SHALL have ports in_valid/in_ready  in/out  1  operand push handshake; in_a, in_b  in  16  signed Q6.9 operands.
REQ-006 SHALL have ports start  in  1  vector start; vec_len  in  5  pairs per vector, sampled with start.
REQ-007 SHALL have ports mac_a, mac_b  out  16  registered operands to the MAC; mac_clr_n  out  1  registered MAC clear, active-low.
REQ-008 SHALL have port mac_result  in  16  MAC accumulator output.
REQ-009 SHALL have ports res_valid/res_ready  out/in  1  result handshake; res_data  out  16  captured dot product; busy  out  1  high when state is not IDLE.

Function
REQ-010 FIFO SHALL push on in_valid&&in_ready; in_ready = !full; occupancy 0..DEPTH.
REQ-011 FIFO SHALL accept pushes in every FSM state, including DONE.
REQ-012 FSM states SHALL be IDLE, CLEAR, ISSUE, DRAIN, DONE.
REQ-013 IDLE: start with vec_len!=0 latches vec_len into remaining count -> CLEAR; start with vec_len==0 is ignored.
REQ-014 start outside IDLE SHALL be ignored.
REQ-015 CLEAR: one cycle, mac_clr_n=0, mac_a/mac_b=0 -> ISSUE.
REQ-016 ISSUE: FIFO non-empty -> pop one pair onto mac_a/mac_b at the cycle-ending edge and decrement remaining; FIFO empty -> load 0/0 (bubble, contributes 0).
REQ-017 Push and pop SHALL never share an entry: an empty FIFO does not pop on the same edge it is written.
REQ-018 The edge that loads the final pair SHALL move the FSM to DRAIN and clear the drain counter.
REQ-019 DRAIN: mac_a/mac_b=0; res_data <= mac_result on the LAT-th edge after the final-pair load -> DONE.
REQ-020 DONE: res_valid=1 with res_data stable until res_ready; the edge with res_valid&&res_ready -> IDLE, res_valid=0.
REQ-021 Latency with a pre-filled FIFO of N pairs: res_valid rises N+6 edges after the start edge.
REQ-022 Sequencer SHALL perform no arithmetic on data; rounding and saturation are the MAC's.

Reset
REQ-023 On rst low SHALL asynchronously set: state IDLE, FIFO empty, in_ready 1, mac_a/mac_b 0, mac_clr_n 0, res_valid 0, res_data 0, busy 0.
REQ-024 mac_clr_n SHALL go to 1 on the first edge after rst release, so the MAC is held cleared throughout reset.
REQ-025 Reset mid-vector SHALL discard queued operands and any partial result; no res_valid follows.

Structure
REQ-026 Shared package mac_pkg SHALL hold DATA_W=16, default DEPTH, LAT, and the FSM state enum.
REQ-027 FIFO SHALL be sub-module mac_seq_fifo (push/pop, full, empty, count); FSM and drain counter stay in the top.

Verification
REQ-028 Push 4x(0x0200,0x0200), then start with vec_len=4 -> res_data=0x0800; res_valid rises exactly 10 edges after start.
REQ-029 Start with vec_len=3 on an empty FIFO, then push 3x(0x0200,0x0400) with 2-cycle gaps -> res_data=0x0C00.
REQ-030 Run vec_len=3 with 3x(0x7FFF,0x7FFF) -> res_data=0x7FFF (saturated).
REQ-031 Push 17 pairs with no start -> in_ready=0 after the 16th; the 17th is held and accepted after the first pop.
REQ-032 Assert rst during ISSUE of a vec_len=8 vector -> all outputs at reset values; a following vec_len=1 vector of (0x0200,0x0200) -> 0x0200.
REQ-033 Hold res_ready=0 for 5 cycles in DONE and pulse start -> res_data stable, no new vector; start with vec_len=0 in IDLE -> busy stays 0.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared definitions for the MAC vector sequencer: data width, default sizing
// and the sequencer FSM state encoding.
package mac_pkg;

   localparam int DATA_W    = 16;
   localparam int DEPTH_DEF = 16;
   localparam int LAT_DEF   = 5;
   localparam int LEN_W     = 5;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLEAR = 3'd1,
      ST_ISSUE = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } mac_state_e;

endpackage

// File: rtl/mac_seq_fifo.sv
// Operand-pair FIFO with show-ahead read data; the head entry is visible on
// pop_data whenever empty is low, and occupancy is reported as 0..DEPTH.
module mac_seq_fifo
   import mac_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int WIDTH = 2 * DATA_W
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic [WIDTH-1:0]             push_data,
   input  logic                         pop,
   output logic [WIDTH-1:0]             pop_data,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_do_push;
   logic             w_do_pop;

   // Gating on the registered flags keeps a write into an empty FIFO from
   // being popped on the same edge.
   assign w_do_push = push && !full;
   assign w_do_pop  = pop && !empty;
   assign full      = (r_count == CNT_W'(DEPTH));
   assign empty     = (r_count == '0);
   assign count     = r_count;
   assign pop_data  = r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/mac_vector_sequencer.sv
// Feeds queued operand pairs to an external MAC one per cycle, waits out the
// MAC latency and presents the captured dot product on a result handshake.
module mac_vector_sequencer
   import mac_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int LAT   = LAT_DEF
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [DATA_W-1:0]            in_a,
   input  logic [DATA_W-1:0]            in_b,
   input  logic                         start,
   input  logic [LEN_W-1:0]             vec_len,
   output logic [DATA_W-1:0]            mac_a,
   output logic [DATA_W-1:0]            mac_b,
   output logic                         mac_clr_n,
   input  logic [DATA_W-1:0]            mac_result,
   output logic                         res_valid,
   input  logic                         res_ready,
   output logic [DATA_W-1:0]            res_data,
   output logic                         busy,
   output mac_state_e                   dbg_state,
   output logic [$clog2(DEPTH+1)-1:0]   dbg_fifo_count
);

   localparam int DRN_W = (LAT > 1) ? $clog2(LAT) : 1;

   // Both handshakes transfer on a rising edge where valid && ready; a
   // producer holds valid and data stable until that edge.
   mac_state_e            r_state;
   logic [LEN_W-1:0]      r_remaining;
   logic [DRN_W-1:0]      r_drain_cnt;
   logic [DATA_W-1:0]     r_mac_a;
   logic [DATA_W-1:0]     r_mac_b;
   logic                  r_mac_clr_n;
   logic                  r_res_valid;
   logic [DATA_W-1:0]     r_res_data;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_full;
   logic                  w_empty;
   logic [2*DATA_W-1:0]   w_pop_data;

   assign in_ready  = !w_full;
   assign w_push    = in_valid && !w_full;
   assign w_pop     = (r_state == ST_ISSUE) && !w_empty;
   assign mac_a     = r_mac_a;
   assign mac_b     = r_mac_b;
   assign mac_clr_n = r_mac_clr_n;
   assign res_valid = r_res_valid;
   assign res_data  = r_res_data;
   assign busy      = (r_state != ST_IDLE);
   assign dbg_state = r_state;

   mac_seq_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (2 * DATA_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (w_push),
      .push_data ({in_a, in_b}),
      .pop       (w_pop),
      .pop_data  (w_pop_data),
      .full      (w_full),
      .empty     (w_empty),
      .count     (dbg_fifo_count)
   );

   // Operands default to zero each cycle so CLEAR, bubbles and DRAIN add nothing.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= ST_IDLE;
         r_remaining <= '0;
         r_drain_cnt <= '0;
         r_mac_a     <= '0;
         r_mac_b     <= '0;
         r_mac_clr_n <= 1'b0;
         r_res_valid <= 1'b0;
         r_res_data  <= '0;
      end else begin
         r_mac_clr_n <= 1'b1;
         r_mac_a     <= '0;
         r_mac_b     <= '0;
         case (r_state)
            ST_IDLE: begin
               if (start && (vec_len != '0)) begin
                  r_remaining <= vec_len;
                  r_mac_clr_n <= 1'b0;
                  r_state     <= ST_CLEAR;
               end
            end
            ST_CLEAR: r_state <= ST_ISSUE;
            ST_ISSUE: begin
               if (w_pop) begin
                  {r_mac_a, r_mac_b} <= w_pop_data;
                  r_remaining        <= r_remaining - LEN_W'(1);
                  if (r_remaining == LEN_W'(1)) begin
                     r_drain_cnt <= '0;
                     r_state     <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               if (r_drain_cnt == DRN_W'(LAT - 1)) begin
                  r_res_data  <= mac_result;
                  r_res_valid <= 1'b1;
                  r_state     <= ST_DONE;
               end else begin
                  r_drain_cnt <= r_drain_cnt + DRN_W'(1);
               end
            end
            ST_DONE: begin
               if (res_ready) begin
                  r_res_valid <= 1'b0;
                  r_state     <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mac_vector_sequencer.sv
// Bench for mac_vector_sequencer: a saturating Q6.9 MAC model closes the loop,
// directed table vectors and corner sequences, then randomized vectors.
module tb_mac_vector_sequencer;
   import mac_pkg::*;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_a;
   logic [15:0] in_b;
   logic        start;
   logic [4:0]  vec_len;
   logic [15:0] mac_a;
   logic [15:0] mac_b;
   logic        mac_clr_n;
   logic [15:0] mac_result;
   logic        res_valid;
   logic        res_ready;
   logic [15:0] res_data;
   logic        busy;
   mac_state_e  dbg_state;
   logic [4:0]  dbg_fifo_count;

   int checks   = 0;
   int failures = 0;

   logic [31:0] pair_q[$];
   logic [15:0] exp_q[$];
   logic [15:0] mac_acc;

   typedef struct {
      logic [4:0]  len;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] exp_res;
      int          exp_lat;
   } vec_t;
   vec_t tbl[5];

   mac_vector_sequencer #(.DEPTH(16), .LAT(5)) dut (
      .clk            (clk),
      .rst            (rst),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_a           (in_a),
      .in_b           (in_b),
      .start          (start),
      .vec_len        (vec_len),
      .mac_a          (mac_a),
      .mac_b          (mac_b),
      .mac_clr_n      (mac_clr_n),
      .mac_result     (mac_result),
      .res_valid      (res_valid),
      .res_ready      (res_ready),
      .res_data       (res_data),
      .busy           (busy),
      .dbg_state      (dbg_state),
      .dbg_fifo_count (dbg_fifo_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Q6.9 product truncated back to Q6.9, accumulated with saturation.
   function automatic logic [15:0] mac_step(input logic [15:0] acc, input logic [15:0] a,
                                            input logic [15:0] b);
      longint s;
      s = longint'($signed(acc)) + ((longint'($signed(a)) * longint'($signed(b))) >>> 9);
      if (s > 32767) s = 32767;
      else if (s < -32768) s = -32768;
      return 16'(s);
   endfunction

   always @(posedge clk) begin
      if (!mac_clr_n) mac_acc <= 16'h0000;
      else            mac_acc <= mac_step(mac_acc, mac_a, mac_b);
   end
   assign mac_result = mac_acc;

   always @(posedge clk) begin
      if (rst && in_valid && in_ready) pair_q.push_back({in_a, in_b});
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] rnd_op();
      return 16'($urandom_range(0, 2047)) - 16'd1024;
   endfunction

   // Reference: a vector consumes the next len accepted pairs in order.
   task automatic model_vector(input int len);
      logic [15:0] acc;
      logic [31:0] p;
      acc = 16'h0000;
      for (int i = 0; i < len; i++) begin
         if (pair_q.size() == 0) break;
         p   = pair_q.pop_front();
         acc = mac_step(acc, p[31:16], p[15:0]);
      end
      exp_q.push_back(acc);
   endtask

   task automatic push_pair(input logic [15:0] a, input logic [15:0] b);
      int n;
      @(negedge clk);
      in_a = a; in_b = b; in_valid = 1'b1; n = 0;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         checks++; failures++;
         $display("FAIL push_timeout: in_ready=0 after %0d cycles, required 1", n);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic start_vec(input logic [4:0] len);
      @(negedge clk);
      start = 1'b1; vec_len = len;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_result(output int edges);
      edges = 0;
      while (edges < 400) begin
         @(posedge clk); edges++; #1;
         if (res_valid) break;
      end
      if (!res_valid) begin
         checks++; failures++;
         $display("FAIL result_timeout: res_valid=0 after %0d edges, required 1", edges);
      end
   endtask

   task automatic ack();
      @(negedge clk);
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running at %0t, required finished", $time);
      $fatal(1);
   end

   initial begin
      int          edges;
      int          len;
      int          pre;
      logic        seen;
      logic [15:0] held;

      tbl[0] = '{5'd4, 16'h0200, 16'h0200, 16'h0800, 10};
      tbl[1] = '{5'd3, 16'h7FFF, 16'h7FFF, 16'h7FFF, 9};
      tbl[2] = '{5'd2, 16'h0200, 16'hFE00, 16'hFC00, 8};
      tbl[3] = '{5'd1, 16'h8000, 16'h0200, 16'h8000, 7};
      tbl[4] = '{5'd5, 16'h0100, 16'h0100, 16'h0280, 11};

      rst = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
      start = 1'b0; vec_len = '0; res_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready",  in_ready,  1);
      check("rst_mac_a",     mac_a,     0);
      check("rst_mac_b",     mac_b,     0);
      check("rst_mac_clr_n", mac_clr_n, 0);
      check("rst_res_valid", res_valid, 0);
      check("rst_res_data",  res_data,  0);
      check("rst_busy",      busy,      0);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      check("clr_n_after_release", mac_clr_n, 1);

      for (int t = 0; t < 5; t++) begin
         for (int j = 0; j < int'(tbl[t].len); j++) push_pair(tbl[t].a, tbl[t].b);
         start_vec(tbl[t].len);
         wait_result(edges);
         check($sformatf("tbl%0d_latency", t), edges, tbl[t].exp_lat);
         check($sformatf("tbl%0d_res", t), res_data, tbl[t].exp_res);
         model_vector(int'(tbl[t].len));
         void'(exp_q.pop_front());
         ack();
         check($sformatf("tbl%0d_ack", t), res_valid, 0);
      end

      // Start on an empty FIFO, operands trickle in with gaps.
      start_vec(5'd3);
      for (int j = 0; j < 3; j++) begin
         repeat (2) @(posedge clk);
         push_pair(16'h0200, 16'h0400);
      end
      wait_result(edges);
      check("gap_res", res_data, 16'h0C00);
      model_vector(3); void'(exp_q.pop_front());
      ack();

      // Fill to capacity; the 17th pair waits for the first pop.
      for (int j = 0; j < 16; j++) push_pair(16'h0200, 16'h0040);
      @(negedge clk);
      check("full_after_16", in_ready, 0);
      fork
         push_pair(16'h0200, 16'h0040);
         begin
            repeat (3) @(negedge clk);
            check("held_17th_ready", in_ready, 0);
            check("held_17th_count", dbg_fifo_count, 16);
            start_vec(5'd17);
            wait_result(edges);
         end
      join
      check("full_latency", edges, 23);
      check("full_res", res_data, 16'h0440);
      model_vector(17); void'(exp_q.pop_front());
      ack();

      // Reset in the middle of an issuing vector.
      for (int j = 0; j < 8; j++) push_pair(16'h0100, 16'h0100);
      start_vec(5'd8);
      repeat (3) @(posedge clk);
      #2;
      check("pre_rst_state", dbg_state, ST_ISSUE);
      rst = 1'b0;
      #1;
      check("mid_rst_busy",      busy,           0);
      check("mid_rst_mac_a",     mac_a,          0);
      check("mid_rst_mac_b",     mac_b,          0);
      check("mid_rst_clr_n",     mac_clr_n,      0);
      check("mid_rst_res_valid", res_valid,      0);
      check("mid_rst_res_data",  res_data,       0);
      check("mid_rst_in_ready",  in_ready,       1);
      check("mid_rst_count",     dbg_fifo_count, 0);
      pair_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (res_valid || busy) seen = 1'b1;
      end
      check("no_result_after_rst", seen, 0);
      push_pair(16'h0200, 16'h0200);
      start_vec(5'd1);
      wait_result(edges);
      check("post_rst_res", res_data, 16'h0200);
      model_vector(1); void'(exp_q.pop_front());
      ack();

      // Stall in DONE with a stray start, then a zero-length start in IDLE.
      for (int j = 0; j < 2; j++) push_pair(16'h0200, 16'h0300);
      start_vec(5'd2);
      wait_result(edges);
      held = res_data;
      check("done_res", res_data, 16'h0600);
      repeat (2) @(negedge clk);
      start = 1'b1; vec_len = 5'd2;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      check("done_stall_valid", res_valid, 1);
      check("done_stall_data",  res_data,  held);
      check("done_stall_state", dbg_state, ST_DONE);
      model_vector(2); void'(exp_q.pop_front());
      ack();
      repeat (3) @(negedge clk);
      check("done_start_ignored", busy, 0);
      start_vec(5'd0);
      seen = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (busy) seen = 1'b1;
      end
      check("zero_len_ignored", seen, 0);

      for (int it = 0; it < 20; it++) begin
         len = $urandom_range(1, 20);
         pre = $urandom_range(0, (len > 12) ? 12 : len);
         for (int j = 0; j < pre; j++) push_pair(rnd_op(), rnd_op());
         fork
            begin
               for (int j = pre; j < len; j++) begin
                  repeat ($urandom_range(0, 3)) @(posedge clk);
                  push_pair(rnd_op(), rnd_op());
               end
            end
            begin
               repeat ($urandom_range(0, 4)) @(posedge clk);
               start_vec(5'(len));
               wait_result(edges);
            end
         join
         model_vector(len);
         check($sformatf("rand%0d_res", it), res_data, exp_q.pop_front());
         repeat ($urandom_range(0, 3)) @(posedge clk);
         ack();
         check($sformatf("rand%0d_ack", it), res_valid, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
